// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus sequencer: register indices and FSM encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package reg_bus_pkg;

    // Width of a source/destination register index
    localparam int unsigned IDX_W = 4;
    // Number of requesters sharing the bus
    localparam int unsigned N_REQ = 2;

    // Register file map
    localparam int unsigned IDX_R      = 0;
    localparam int unsigned IDX_ROW    = 1;
    localparam int unsigned IDX_CAT    = 2;
    localparam int unsigned IDX_CB     = 3;
    localparam int unsigned IDX_RNOW   = 4;
    localparam int unsigned IDX_CATNOW = 5;
    localparam int unsigned IDX_CBNOW  = 6;
    localparam int unsigned IDX_ALPHAP = 7;
    localparam int unsigned IDX_BETAP  = 8;
    localparam int unsigned IDX_GAMMAP = 9;
    localparam int unsigned IDX_TOTAL  = 10;

    // Default register count: every named register above
    localparam int unsigned REG_COUNT_DEFAULT = IDX_TOTAL + 1;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/reg_sel_dec.sv
// Register index to one-hot select decoder with out-of-range flag.
// Latency: purely combinational.
// Backpressure: none; an out-of-range index yields an all-zero select.
module reg_sel_dec
    import reg_bus_pkg::*;
#(
    parameter int unsigned N = REG_COUNT_DEFAULT
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     sel,
    output logic             oor
);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(idx);

    // Decode the index; indices past the register file select nothing
    always_comb begin
        sel = '0;
        oor = (idx_ext >= 32'(N));
        for (int i = 0; i < int'(N); i++) begin
            if (idx_ext == 32'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Register-to-register move sequencer for two requesters; round-robin tie break with REG_BUS_RR_ARB_EN, fixed priority (req 0) otherwise.
// Latency: 3 cycles handshake-to-done (IDLE grant, READ capture, WRITE commit); one transfer per 3 cycles.
// Backpressure: req_ready is high only in IDLE for the granted requester; all other cycles stall requesters.
module reg_bus_sequencer
    import reg_bus_pkg::*;
#(
    parameter int unsigned reg_count = REG_COUNT_DEFAULT,
    parameter int unsigned reg_width = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [IDX_W-1:0]     req0_src,
    input  logic [IDX_W-1:0]     req0_dst,
    input  logic [IDX_W-1:0]     req1_src,
    input  logic [IDX_W-1:0]     req1_dst,
    output logic [reg_count-1:0] read_en,
    output logic [reg_count-1:0] write_en,
    input  logic [reg_width-1:0] bus_in,
    output logic [reg_width-1:0] bus_out,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     dst_q, dst_d;
    logic                 gnt_q, gnt_d;
    logic [reg_width-1:0] hold_q, hold_d;
    logic                 gnt_sel;

    logic [reg_count-1:0] src_oh;
    logic [reg_count-1:0] dst_oh;
    logic                 src_oor;
    logic                 dst_oor;
    logic                 bad_idx;

`ifdef REG_BUS_RR_ARB_EN
    logic rr_last_q, rr_last_d;
`endif

    reg_sel_dec #(.N(reg_count)) u_src_dec (
        .idx (src_q),
        .sel (src_oh),
        .oor (src_oor)
    );

    reg_sel_dec #(.N(reg_count)) u_dst_dec (
        .idx (dst_q),
        .sel (dst_oh),
        .oor (dst_oor)
    );

    // Any bad index turns the whole transfer into an error with no bus activity
    assign bad_idx = src_oor | dst_oor;

    // The write data bus mirrors the hold register in every state
    assign bus_out = hold_q;

    // Pick which requester wins the next grant
    always_comb begin
`ifdef REG_BUS_RR_ARB_EN
        if (&req_valid) begin
            gnt_sel = ~rr_last_q;
        end else begin
            gnt_sel = ~req_valid[0];
        end
`else
        gnt_sel = ~req_valid[0];
`endif
    end

    // Next-state and output decode; reset masks all strobes so an aborted move leaves no trace
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        req_ready = '0;
        read_en   = '0;
        write_en  = '0;
        done      = '0;
        err       = '0;
`ifdef REG_BUS_RR_ARB_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt_sel] = 1'b1;
                    src_d   = gnt_sel ? req1_src : req0_src;
                    dst_d   = gnt_sel ? req1_dst : req0_dst;
                    gnt_d   = gnt_sel;
                    state_d = READ;
`ifdef REG_BUS_RR_ARB_EN
                    rr_last_d = gnt_sel;
`endif
                end
            end
            READ: begin
                if (!bad_idx) begin
                    read_en = src_oh;
                end
                hold_d  = bus_in;
                state_d = WRITE;
            end
            WRITE: begin
                if (!bad_idx) begin
                    write_en     = dst_oh;
                    done[gnt_q]  = 1'b1;
                end else begin
                    err[gnt_q]   = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            req_ready = '0;
            read_en   = '0;
            write_en  = '0;
            done      = '0;
            err       = '0;
        end
    end

    // Transfer state and latched request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            gnt_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

`ifdef REG_BUS_RR_ARB_EN
    // Last-granted pointer; reset value makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer with a behavioural register file.
// Latency: expects READ one cycle after handshake and WRITE/done two cycles after.
// Backpressure: requesters hold valid until req_ready is seen.
module tb_reg_bus_sequencer;

    localparam int RC = 11;
    localparam int RW = 12;

    typedef struct {
        int         id;
        logic [3:0] src;
        logic [3:0] dst;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [3:0]    req0_src = '0;
    logic [3:0]    req0_dst = '0;
    logic [3:0]    req1_src = '0;
    logic [3:0]    req1_dst = '0;
    logic [RC-1:0] read_en;
    logic [RC-1:0] write_en;
    logic [RW-1:0] bus_in;
    logic [RW-1:0] bus_out;
    logic [1:0]    done;
    logic [1:0]    err;

    logic [RW-1:0] tb_mem [RC];
    exp_t          exp_q[$];
    int            gnt_log[$];
    int            checks = 0;
    int            failures = 0;
    int            hs_cnt = 0;
    int            cmp_cnt = 0;
    int            abort_cnt = 0;

    always #5 clk = ~clk;

    reg_bus_sequencer #(.reg_count(RC), .reg_width(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_src  (req0_src),
        .req0_dst  (req0_dst),
        .req1_src  (req1_src),
        .req1_dst  (req1_dst),
        .read_en   (read_en),
        .write_en  (write_en),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .done      (done),
        .err       (err)
    );

    function automatic logic [RW-1:0] init_val(input int i);
        return (i == 8) ? 12'd900 : 12'(i * 37 + 5);
    endfunction

    function automatic logic [RC-1:0] oh11(input logic [3:0] i);
        logic [RC-1:0] r;
        r = '0;
        for (int k = 0; k < RC; k++) begin
            if (int'(i) == k) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural register file: combinational read, write on clock edge
    initial begin
        for (int i = 0; i < RC; i++) tb_mem[i] <= init_val(i);
    end

    always @(posedge clk) begin
        for (int i = 0; i < RC; i++) begin
            if (write_en[i]) tb_mem[i] <= bus_out;
        end
    end

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < RC; i++) begin
            if (read_en == (11'd1 << i)) bus_in = tb_mem[i];
        end
    end

    // Handshake observer: pushes the expected transfer when a grant is accepted
    initial begin : observer
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (req_ready[0] && req_valid[0]) begin
                    exp_q.push_back('{id: 0, src: req0_src, dst: req0_dst});
                    gnt_log.push_back(0);
                    hs_cnt++;
                end
                if (req_ready[1] && req_valid[1]) begin
                    exp_q.push_back('{id: 1, src: req1_src, dst: req1_dst});
                    gnt_log.push_back(1);
                    hs_cnt++;
                end
            end
        end
    end

    // Monitor: tracks the expected READ/WRITE cycles and compares against the queue head
    initial begin : monitor
        int            phase;
        exp_t          cur;
        bit            bad;
        logic [1:0]    pulse;
        logic [RW-1:0] ref_mem [RC];
        bit            inv_ok;
        phase = 0;
        for (int i = 0; i < RC; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            #2;
            inv_ok = $onehot0(read_en) && $onehot0(write_en) && !((|read_en) && (|write_en));
            check("onehot_excl", 32'(inv_ok), 32'd1);
            if (reset) begin
                check("rst_outputs", 32'({read_en, write_en, done, err, req_ready}), 32'd0);
                if (phase != 0) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    abort_cnt++;
                    phase = 0;
                end
            end else begin
                case (phase)
                    0: begin
                        check("idle_strobes", 32'({read_en, write_en, done, err}), 32'd0);
                        if ((req_ready & req_valid) != 2'b00) phase = 1;
                    end
                    1: begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
                            phase = 0;
                        end else begin
                            cur = exp_q[0];
                            bad = (cur.src >= 4'd11) || (cur.dst >= 4'd11);
                            check("read_en", 32'(read_en), 32'(bad ? 11'd0 : oh11(cur.src)));
                            check("read_others", 32'({write_en, done, err, req_ready}), 32'd0);
                            phase = 2;
                        end
                    end
                    default: begin
                        void'(exp_q.pop_front());
                        pulse = 2'b01 << cur.id;
                        check("write_en", 32'(write_en), 32'(bad ? 11'd0 : oh11(cur.dst)));
                        check("done", 32'(done), 32'(bad ? 2'b00 : pulse));
                        check("err", 32'(err), 32'(bad ? pulse : 2'b00));
                        check("write_rd_ready", 32'({read_en, req_ready}), 32'd0);
                        if (!bad) begin
                            check("bus_out", 32'(bus_out), 32'(ref_mem[int'(cur.src)]));
                            ref_mem[int'(cur.dst)] = ref_mem[int'(cur.src)];
                        end
                        cmp_cnt++;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Present one request from a negedge and hold it until accepted
    task automatic issue(input int id, input logic [3:0] s, input logic [3:0] d);
        bit got;
        got = 1'b0;
        if (id == 0) begin
            req0_src = s;
            req0_dst = d;
            req_valid = 2'b01;
        end else begin
            req1_src = s;
            req1_dst = d;
            req_valid = 2'b10;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            @(negedge clk);
        end
        req_valid = 2'b00;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout actual=no_ready required=ready id=%0d", id);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    int exp_seq[4];
    int start;

    initial begin : stim
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_bus_out", 32'(bus_out), 32'd0);
        check("rst_idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);

        // Single move betap -> Total
        issue(0, 4'd8, 4'd10);
        // Same source and destination
        issue(0, 4'd5, 4'd5);
        // Bad source, bad destination
        issue(1, 4'd12, 4'd3);
        issue(1, 4'd2, 4'd13);

        // Source input changes while the move is in flight
        issue(0, 4'd8, 4'd2);
        req0_src = 4'd9;
        repeat (3) @(negedge clk);
        check("inflight_data", 32'(tb_mem[2]), 32'd900);
        check("same_reg_data", 32'(tb_mem[5]), 32'(init_val(5)));

        // Reset during READ of 1 -> 7
        start = cmp_cnt;
        issue(0, 4'd1, 4'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(cmp_cnt), 32'(start));
        check("abort_mem7", 32'(tb_mem[7]), 32'(init_val(7)));
        check("abort_hold", 32'(bus_out), 32'd0);

        // Tie between both requesters
`ifdef REG_BUS_RR_ARB_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        start = gnt_log.size();
        req0_src = 4'd2; req0_dst = 4'd3;
        req1_src = 4'd4; req1_dst = 4'd5;
        req_valid = 2'b11;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #3;
            if (gnt_log.size() >= start + 4) break;
        end
        @(negedge clk);
        req_valid = 2'b00;
        check("tie_grant_count", 32'(gnt_log.size() >= start + 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (gnt_log.size() > start + k) check("tie_grant", 32'(gnt_log[start + k]), 32'(exp_seq[k]));
        end
        repeat (3) @(negedge clk);

        // Random stress
        for (int n = 0; n < 1000; n++) begin
            issue(int'($urandom_range(0, 1)), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 12)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("hs_vs_completions", 32'(hs_cnt), 32'(cmp_cnt + abort_cnt));
        check("abort_count", 32'(abort_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bus_sequencer.md
REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

Interface
REQ-001 SHALL have parameter reg_count, default 11, meaning number of register file entries (R plus register set).
REQ-002 SHALL have parameter reg_width, default 12, meaning the data bus width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid, input, 2, and req_ready, output, 2, one valid/ready handshake per requester (0 = control unit, 1 = auxiliary).
REQ-006 SHALL have ports req0_src/req0_dst and req1_src/req1_dst, input, 4 each, holding the source and destination register index.
REQ-007 SHALL have port read_en, output, reg_count, a one-hot read select to the register file.
REQ-008 SHALL have port write_en, output, reg_count, a one-hot write select to the register file.
REQ-009 SHALL have port bus_in, input, reg_width, the register file dataout.
REQ-010 SHALL have port bus_out, output, reg_width, the register file datain.
REQ-011 SHALL have ports done, output, 2, and err, output, 2, one-cycle completion and bad-index pulses per requester.

Function
REQ-012 SHALL implement FSM states IDLE, READ and WRITE.
REQ-013 IDLE: with any req_valid high, SHALL grant one requester, assert its req_ready combinationally in that cycle, latch its src/dst and grant id, then go to READ.
REQ-014 req_ready SHALL be high only in IDLE and only for the granted requester; both bits SHALL be low in all other states.
REQ-015 READ: SHALL drive read_en = onehot(src) and write_en = 0, capture bus_in into the hold register at the clock edge, then go to WRITE.
REQ-016 WRITE: SHALL drive write_en = onehot(dst), read_en = 0 and bus_out = hold, pulse done[grant] for one cycle, then go to IDLE.
REQ-017 Latency SHALL be 3 cycles from handshake to done, giving a peak throughput of one transfer per 3 cycles; there SHALL be no back-to-back skip of IDLE.
REQ-018 read_en and write_en SHALL never both be nonzero in the same cycle, and each SHALL have at most one bit set.
REQ-019 src == dst SHALL be a legal transfer, and its result SHALL be unchanged data.
REQ-020 A src or dst index >= reg_count SHALL still be accepted, SHALL drive enables all-zero in READ and WRITE, SHALL pulse err[grant] in WRITE, and SHALL NOT pulse done.
REQ-021 bus_out SHALL always equal the hold register, whatever the state.
REQ-022 Requests SHALL be sampled only at the handshake; later changes to src/dst SHALL NOT affect an in-flight transfer.

Reset
REQ-023 On reset, the FSM SHALL go to IDLE, and read_en, write_en, done, err and hold SHALL become 0; req_ready SHALL then follow REQ-013.
REQ-024 Reset during READ or WRITE SHALL abort the transfer: no write_en, done or err SHALL be asserted for it.
REQ-025 The round-robin pointer SHALL reset to favour requester 0.

Configuration
REQ-026 With macro REG_BUS_RR_ARB_EN defined, arbitration SHALL be round-robin: on a tie, the requester not granted last wins, and the pointer SHALL update at each grant.
REQ-027 Without REG_BUS_RR_ARB_EN, arbitration SHALL be fixed priority, with requester 0 always winning a tie.

Structure
REQ-028 Register index constants (R=0, row=1, cAT=2, cB=3, rnow=4, cATnow=5, cBnow=6, alphap=7, betap=8, gammap=9, Total=10) and the FSM state encoding SHALL live in shared package reg_bus_pkg.
REQ-029 Index-to-one-hot decode with out-of-range detect SHALL be sub-module reg_sel_dec, instantiated twice (src, dst).

Verification
REQ-030 Single transfer: req0 src=8 (betap), dst=10 (Total), bus_in=900 in READ -> read_en=0x100, then write_en=0x400, bus_out=900, done[0] at cycle 3.
REQ-031 Tie: both valid every cycle (req0 2->3, req1 4->5) -> with REG_BUS_RR_ARB_EN, grants alternate 0,1,0,1; without it, only requester 0 is granted while it stays valid.
REQ-032 Bad index: req1 src=12, dst=3 -> read_en and write_en stay 0, err[1] pulses at cycle 3, done stays 0.
REQ-033 Reset asserted during READ of a 1->7 transfer -> next cycle is IDLE, write_en never becomes 0x080, and no done is seen.
REQ-034 src changed from 8 to 9 during READ -> read_en stays 0x100 and the captured data is unaffected.
REQ-035 Random stress over 1000 transfers -> one-hot and mutual-exclusion checks (REQ-018) never fail, and every handshake yields exactly one done or err.
